axi4_lite_regfile: RTL

AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

---
 rtl/axi4_lite_pkg.sv | 40 ++++
 rtl/axi4_lite_regfile_mem.sv | 41 ++++
 rtl/axi4_lite_regfile.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared constants for the AXI4-Lite register file: response
//               codes, write/read FSM state encodings, byte-strobe merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write channel FSM: address and data may arrive in either order
   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_HAVE_ADDR = 2'd1,
      W_HAVE_DATA = 2'd2,
      W_RESP      = 2'd3
   } wr_state_t;

   // Read channel FSM
   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_RESP = 1'b1
   } rd_state_t;

   // Replace only the bytes whose strobe bit is set
   function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile_mem
// Description : NUM_REGS x 32-bit register storage with one byte-strobed write
//               port and a flat, zero-latency view of every register.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile_mem
   import axi4_lite_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      wr_en,
   input  logic [IDX_W-1:0]          wr_index,
   input  logic [31:0]               wr_data,
   input  logic [3:0]                wr_strb,
   output logic [32*NUM_REGS-1:0]    regs_flat
);

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
         logic [31:0] r_word;

         // One register; updates only the strobed bytes when addressed
         always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
               r_word <= '0;
            end else if (wr_en && (wr_index == IDX_W'(i))) begin
               r_word <= strb_merge(r_word, wr_data, wr_strb);
            end
         end

         assign regs_flat[32*i +: 32] = r_word;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_regfile
// Description : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers
//               at BASE_ADDR, with independent write and read channels.
//               Optional macro AXI4_LITE_REGFILE_PROT_CHECK_EN rejects
//               unprivileged accesses (prot[0]=0) with SLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_regfile
   import axi4_lite_pkg::*;
#(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic [31:0]            awaddr_in,
   input  logic [2:0]             awprot_in,
   input  logic                   awvalid_in,
   output logic                   awready_out,
   input  logic [31:0]            wdata_in,
   input  logic [3:0]             wstrb_in,
   input  logic                   wvalid_in,
   output logic                   wready_out,
   output logic [1:0]             bresp_out,
   output logic                   bvalid_out,
   input  logic                   bready_in,
   input  logic [31:0]            araddr_in,
   input  logic [2:0]             arprot_in,
   input  logic                   arvalid_in,
   output logic                   arready_out,
   output logic [31:0]            rdata_out,
   output logic [1:0]             rresp_out,
   output logic                   rvalid_out,
   input  logic                   rready_in,
   output logic [32*NUM_REGS-1:0] regs_out
);

   localparam int          c_idx_w = $clog2(NUM_REGS);
   localparam logic [31:0] c_span  = 32'(NUM_REGS * 4);

   // ------------------------------------------------------------------------
   // Write channel state
   // ------------------------------------------------------------------------
   wr_state_t   r_wstate;
   logic        r_awready;
   logic        r_wready;
   logic        r_bvalid;
   logic [1:0]  r_bresp;
   logic [31:0] r_aw_addr;
   logic [2:0]  r_aw_prot;
   logic [31:0] r_w_data;
   logic [3:0]  r_w_strb;

   // ------------------------------------------------------------------------
   // Read channel state
   // ------------------------------------------------------------------------
   rd_state_t   r_rstate;
   logic        r_arready;
   logic        r_rvalid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;

   // ------------------------------------------------------------------------
   // Combinational decode
   // ------------------------------------------------------------------------
   logic               w_aw_hs;
   logic               w_w_hs;
   logic               w_ar_hs;
   logic               w_commit;
   logic [31:0]        w_wr_addr;
   logic [2:0]         w_wr_prot;
   logic [31:0]        w_wr_data;
   logic [3:0]         w_wr_strb;
   logic [31:0]        w_wr_offset;
   logic [31:0]        w_rd_offset;
   logic               w_wr_in_range;
   logic               w_rd_in_range;
   logic               w_wr_ok;
   logic               w_rd_ok;
   logic [c_idx_w-1:0] w_wr_index;
   logic [c_idx_w-1:0] w_rd_index;
   logic [1:0]         w_wr_resp;
   logic [32*NUM_REGS-1:0] w_regs_flat;
   logic [31:0]        w_regs [NUM_REGS];
   logic               w_unused_prot;

   assign w_aw_hs = awvalid_in & r_awready;
   assign w_w_hs  = wvalid_in  & r_wready;
   assign w_ar_hs = arvalid_in & r_arready;

   // Commit happens on the edge where the second half of the pair arrives
   assign w_commit = (w_aw_hs || (r_wstate == W_HAVE_ADDR)) &&
                     (w_w_hs  || (r_wstate == W_HAVE_DATA));

   // Use the captured half if it arrived earlier, otherwise the live bus
   assign w_wr_addr = (r_wstate == W_HAVE_ADDR) ? r_aw_addr : awaddr_in;
   assign w_wr_prot = (r_wstate == W_HAVE_ADDR) ? r_aw_prot : awprot_in;
   assign w_wr_data = (r_wstate == W_HAVE_DATA) ? r_w_data  : wdata_in;
   assign w_wr_strb = (r_wstate == W_HAVE_DATA) ? r_w_strb  : wstrb_in;

   // Address offset from base; addr[1:0] only ever selects bytes, so it is dropped
   assign w_wr_offset   = w_wr_addr - BASE_ADDR;
   assign w_rd_offset   = araddr_in - BASE_ADDR;
   assign w_wr_in_range = (w_wr_offset < c_span);
   assign w_rd_in_range = (w_rd_offset < c_span);
   assign w_wr_index    = w_wr_offset[c_idx_w+1:2];
   assign w_rd_index    = w_rd_offset[c_idx_w+1:2];

`ifdef AXI4_LITE_REGFILE_PROT_CHECK_EN
   assign w_wr_ok = w_wr_in_range & w_wr_prot[0];
   assign w_rd_ok = w_rd_in_range & arprot_in[0];
`else
   assign w_wr_ok = w_wr_in_range;
   assign w_rd_ok = w_rd_in_range;
`endif

   // Protection bits not consumed by the selected build
   assign w_unused_prot = ^{w_wr_prot, arprot_in};

   assign w_wr_resp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   axi4_lite_regfile_mem #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (c_idx_w)
   ) u_mem (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .wr_en     (w_commit & w_wr_ok),
      .wr_index  (w_wr_index),
      .wr_data   (w_wr_data),
      .wr_strb   (w_wr_strb),
      .regs_flat (w_regs_flat)
   );

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_unpack
         assign w_regs[i] = w_regs_flat[32*i +: 32];
      end
   endgenerate

   assign regs_out = w_regs_flat;

   // Write FSM: collects AW and W in any order, commits, then holds B until accepted
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wstate  <= W_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_aw_addr <= '0;
         r_aw_prot <= '0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs && w_w_hs) begin
                  r_wstate  <= W_RESP;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_resp;
               end else if (w_aw_hs) begin
                  r_wstate  <= W_HAVE_ADDR;
                  r_aw_addr <= awaddr_in;
                  r_aw_prot <= awprot_in;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
               end else if (w_w_hs) begin
                  r_wstate  <= W_HAVE_DATA;
                  r_w_data  <= wdata_in;
                  r_w_strb  <= wstrb_in;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b0;
               end else begin
                  // Also re-arms the readies on the first edge after reset
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            W_HAVE_ADDR: begin
               if (w_w_hs) begin
                  r_wstate  <= W_RESP;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_resp;
               end
            end
            W_HAVE_DATA: begin
               if (w_aw_hs) begin
                  r_wstate  <= W_RESP;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b0;
                  r_bvalid  <= 1'b1;
                  r_bresp   <= w_wr_resp;
               end
            end
            W_RESP: begin
               if (bready_in) begin
                  r_wstate  <= W_IDLE;
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            default: begin
               r_wstate  <= W_IDLE;
               r_awready <= 1'b0;
               r_wready  <= 1'b0;
               r_bvalid  <= 1'b0;
            end
         endcase
      end
   end

   // Read FSM: samples data on AR handshake (pre-write value on a same-edge commit)
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rstate  <= R_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_hs) begin
                  r_rstate  <= R_RESP;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rdata   <= w_rd_ok ? w_regs[w_rd_index] : 32'h0;
                  r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_RESP: begin
               if (rready_in) begin
                  r_rstate  <= R_IDLE;
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
               end
            end
            default: begin
               r_rstate  <= R_IDLE;
               r_arready <= 1'b0;
               r_rvalid  <= 1'b0;
            end
         endcase
      end
   end

   assign awready_out = r_awready;
   assign wready_out  = r_wready;
   assign bvalid_out  = r_bvalid;
   assign bresp_out   = r_bresp;
   assign arready_out = r_arready;
   assign rvalid_out  = r_rvalid;
   assign rresp_out   = r_rresp;
   assign rdata_out   = r_rdata;

endmodule
`default_nettype wire
